// File: rtl/alu_pkg.sv
// Shared definitions for the SPI-to-ALU command sequencer: ALU op codes,
// sequencer state encoding and the response status tag.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;

    localparam logic [3:0] STATUS_TAG = 4'h5;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        RESP
    } seq_state_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Inter-byte idle counter: clears on request, counts enabled cycles and
// flags expiry on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module seq_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    // Count idle cycles; restart after a clear or once expiry has fired
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/alu_spi_sequencer.sv
// Byte-level command sequencer between the SPI byte interface and the ALU:
// collects opcode + two 32-bit operands, runs one ALU cycle and returns a
// status byte followed by the 32-bit result, MSB first.
module alu_spi_sequencer
    import alu_pkg::*;
#(
    parameter logic [3:0]  SYNC_NIBBLE    = 4'hA,
    parameter logic [3:0]  MAX_OP         = 4'd8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_abort,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        frame_err
);

    seq_state_t  state;
    logic [1:0]  byte_cnt;
    logic [2:0]  resp_idx;
    logic [3:0]  op_reg;
    logic [31:0] result_reg;
    logic [7:0]  status_reg;

    logic        illegal;
    logic [7:0]  status_next;
    logic [7:0]  next_byte;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;

    // Idle counting only matters while an operand is being collected
    always_comb begin
        tmo_enable = 1'b0;
        tmo_clear  = 1'b1;
        if (state == GET_A || state == GET_B) begin
            tmo_enable = !rx_valid;
            tmo_clear  = rx_valid;
        end
    end

    seq_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    // Status byte for the current op; illegal ops suppress the ALU flags
    always_comb begin
        illegal     = (op_reg > MAX_OP);
        status_next = {STATUS_TAG, illegal, 3'b000};
        if (!illegal) begin
            status_next[2:0] = {alu_overflow, alu_carry, alu_zero};
        end
    end

    // Result byte that follows the one currently presented on tx_data
    always_comb begin
        case (resp_idx)
            3'd0:    next_byte = result_reg[31:24];
            3'd1:    next_byte = result_reg[23:16];
            3'd2:    next_byte = result_reg[15:8];
            default: next_byte = result_reg[7:0];
        endcase
    end

    // Framing FSM with operand shift registers and response streaming
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            resp_idx   <= '0;
            op_reg     <= '0;
            result_reg <= '0;
            status_reg <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (frame_abort && state != IDLE) begin
                state     <= IDLE;
                tx_valid  <= 1'b0;
                busy      <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            if (rx_data[7:4] == SYNC_NIBBLE) begin
                                op_reg   <= rx_data[3:0];
                                byte_cnt <= '0;
                                state    <= GET_A;
                                busy     <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    GET_A: begin
                        if (rx_valid) begin
                            alu_a    <= {alu_a[23:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                state <= GET_B;
                            end
                        end else if (tmo_expired) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    GET_B: begin
                        if (rx_valid) begin
                            alu_b    <= {alu_b[23:0], rx_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                // op is presented together with the final operand byte
                                alu_op <= op_reg;
                                state  <= EXEC;
                            end
                        end else if (tmo_expired) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= 1'b1;
                        end
                    end
                    EXEC: begin
                        if (rx_valid) begin
                            frame_err <= 1'b1;
                        end
                        result_reg <= illegal ? '0 : alu_result;
                        status_reg <= status_next;
                        tx_data    <= status_next;
                        tx_valid   <= 1'b1;
                        resp_idx   <= '0;
                        state      <= RESP;
                    end
                    RESP: begin
                        if (rx_valid) begin
                            frame_err <= 1'b1;
                        end
                        if (tx_valid && tx_ready) begin
                            if (resp_idx == 3'd4) begin
                                tx_valid <= 1'b0;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                tx_data  <= next_byte;
                                resp_idx <= resp_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_spi_sequencer.sv
// Directed bench for alu_spi_sequencer with a small behavioural ALU.
module tb_alu_spi_sequencer;

    localparam int unsigned TMO = 16;

    logic        clock;
    logic        reset;
    logic        frame_abort;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        busy;
    logic        frame_err;

    int unsigned n_checks;
    int unsigned n_pass;

    alu_spi_sequencer #(
        .SYNC_NIBBLE   (4'hA),
        .MAX_OP        (4'd8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_abort (frame_abort),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural ALU: carry is carry-out on ADD and borrow on SUB
    always_comb begin
        logic [32:0] wide;
        wide         = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'd0: begin
                wide         = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = wide[31:0];
                alu_carry    = wide[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd1: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            4'd2:    alu_result = alu_a & alu_b;
            4'd3:    alu_result = alu_a | alu_b;
            4'd4:    alu_result = alu_a ^ alu_b;
            4'd5:    alu_result = ~(alu_a | alu_b);
            4'd6:    alu_result = alu_a << alu_b[4:0];
            4'd7:    alu_result = alu_a >> alu_b[4:0];
            4'd8:    alu_result = $signed(alu_a) >>> alu_b[4:0];
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge; byte is taken at the next edge
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic [7:0] exp_status,
                             input logic [31:0] exp_result);
        logic [7:0] exp_b [5];
        exp_b[0] = exp_status;
        exp_b[1] = exp_result[31:24];
        exp_b[2] = exp_result[23:16];
        exp_b[3] = exp_result[15:8];
        exp_b[4] = exp_result[7:0];
        tx_ready = 1'b1;
        send_byte(cmd);
        send_word(a);
        send_word(b);
        chk({tag, " exec alu_op"}, alu_op, cmd[3:0]);
        chk({tag, " exec tx_valid"}, tx_valid, 1'b0);
        chk({tag, " exec busy"}, busy, 1'b1);
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s tx_valid%0d", tag, i), tx_valid, 1'b1);
            chk($sformatf("%s byte%0d", tag, i), tx_data, exp_b[i]);
            @(posedge clock);
            #1;
        end
        chk({tag, " end tx_valid"}, tx_valid, 1'b0);
        chk({tag, " end busy"}, busy, 1'b0);
    endtask

    initial begin
        int unsigned k;
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        frame_abort = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        tx_ready    = 1'b0;
        #1;
        chk("reset tx_valid", tx_valid, 1'b0);
        chk("reset tx_data", tx_data, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset frame_err", frame_err, 1'b0);
        chk("reset alu_a", alu_a, 32'h0);
        chk("reset alu_b", alu_b, 32'h0);
        chk("reset alu_op", alu_op, 4'h0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_frame("sub", 8'hA1, 32'd5, 32'd3, 8'h50, 32'd2);
        run_frame("add", 8'hA0, 32'hFFFF_FFFF, 32'd1, 8'h53, 32'd0);
        run_frame("illegal", 8'hA9, 32'h1234_5678, 32'h0000_0002, 8'h58, 32'd0);

        // Bad sync byte
        send_byte(8'h3C);
        chk("badsync frame_err", frame_err, 1'b1);
        chk("badsync busy", busy, 1'b0);
        @(posedge clock);
        #1;
        chk("badsync pulse width", frame_err, 1'b0);

        // Abort while idle is ignored
        frame_abort = 1'b1;
        @(posedge clock);
        #1;
        frame_abort = 1'b0;
        chk("idle abort frame_err", frame_err, 1'b0);

        // Timeout partway through operand A
        send_byte(8'hA0);
        send_byte(8'h11);
        send_byte(8'h22);
        k = 0;
        for (int i = 1; i <= int'(TMO) + 4; i++) begin
            @(posedge clock);
            #1;
            if (frame_err) begin
                k = i;
                break;
            end
        end
        chk("timeout cycles", k, TMO);
        chk("timeout busy", busy, 1'b0);
        run_frame("post-timeout", 8'hA0, 32'd1, 32'd2, 8'h50, 32'd3);

        // Stall, overrun and abort during the response
        tx_ready = 1'b0;
        send_byte(8'hA3);
        send_word(32'h1234_0000);
        send_word(32'h0000_5678);
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall valid%0d", i), tx_valid, 1'b1);
            chk($sformatf("stall data%0d", i), tx_data, 8'h50);
            @(posedge clock);
            #1;
        end
        send_byte(8'hA5);
        chk("overrun frame_err", frame_err, 1'b1);
        chk("overrun tx_data", tx_data, 8'h50);
        chk("overrun busy", busy, 1'b1);
        tx_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("overrun pulse width", frame_err, 1'b0);
        chk("resp byte1", tx_data, 8'h12);
        @(posedge clock);
        #1;
        chk("resp byte2", tx_data, 8'h34);
        tx_ready    = 1'b0;
        frame_abort = 1'b1;
        @(posedge clock);
        #1;
        frame_abort = 1'b0;
        chk("abort tx_valid", tx_valid, 1'b0);
        chk("abort frame_err", frame_err, 1'b1);
        chk("abort busy", busy, 1'b0);

        // Async reset in the middle of operand B
        send_byte(8'hA2);
        send_word(32'hAAAA_AAAA);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst alu_a", alu_a, 32'h0);
        chk("async rst alu_b", alu_b, 32'h0);
        chk("async rst alu_op", alu_op, 4'h0);
        chk("async rst busy", busy, 1'b0);
        chk("async rst tx_data", tx_data, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        run_frame("post-reset xor", 8'hA4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 8'h50, 32'hFF00_FF00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
